usb_transmitter: RTL and testbench

USB full-speed style serial transmitter. It is the transmit-side counterpart of usb_receiver.
- On a start request it drives a packet onto d_plus/d_minus: SYNC, PID byte, zero or more data bytes pulled from a show-ahead TX FIFO, then EOP.
- Line coding is NRZI with bit stuffing.
- Sits between the TX FIFO and the bus pads; its bit timing matches what usb_receiver samples.

---
 rtl/usb_transmitter.sv | 215 +++++++++++++++++++++
 tb/tb_usb_transmitter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_transmitter.sv
// USB full-speed style serial transmitter: SYNC, PID, FIFO-fed data bytes and EOP,
// NRZI line coding with optional bit stuffing, one bit every CLKS_PER_BIT clocks.
module usb_transmitter #(
    parameter int CLKS_PER_BIT = 8,
    parameter int EOP_SE0_BITS = 2,
    parameter bit STUFF_EN     = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic [7:0] fifo_r_data,
    input  logic       fifo_empty,
    output logic       fifo_r_enable,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int SW = $clog2(EOP_SE0_BITS + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [SW-1:0] SE0_LAST   = SW'(EOP_SE0_BITS);
    localparam logic [7:0]    SYNC_BYTE  = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_PID     = 3'd2,
        ST_DATA    = 3'd3,
        ST_EOP_SE0 = 3'd4,
        ST_EOP_J   = 3'd5
    } state_t;

    state_t        state_r, state_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [3:0]    bit_idx_r, bit_idx_s;
    logic [7:0]    shift_r, shift_s;
    logic [3:0]    pid_r, pid_s;
    logic [2:0]    ones_r, ones_s;
    logic [SW-1:0] se0_cnt_r, se0_cnt_s;
    logic          level_r, level_s;
    logic          d_plus_r, d_plus_s;
    logic          d_minus_r, d_minus_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          wrap_s, pop_s, emit_bit_s, bit_val_s, advance_s;
    logic          load_byte_s, emit_se0_s, emit_j_s;
    logic [7:0]    load_val_s;

    // NRZI: a 0 toggles the line level, a 1 holds it (level 1 = J)
    function automatic logic nrzi_level(input logic level, input logic data_bit);
        return data_bit ? level : ~level;
    endfunction

    // Next-state, bit sequencing and line-drive decisions
    always_comb begin
        state_s     = state_r;
        pid_s       = pid_r;
        se0_cnt_s   = se0_cnt_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        pop_s       = 1'b0;
        emit_bit_s  = 1'b0;
        bit_val_s   = 1'b0;
        advance_s   = 1'b0;
        load_byte_s = 1'b0;
        load_val_s  = 8'h00;
        emit_se0_s  = 1'b0;
        emit_j_s    = 1'b0;
        wrap_s      = (timer_r == TIMER_LAST);
        if (state_r == ST_IDLE || wrap_s) begin
            timer_s = {TW{1'b0}};
        end else begin
            timer_s = timer_r + TW'(1'b1);
        end

        case (state_r)
            ST_IDLE: begin
                if (tx_start) begin
                    state_s     = ST_SYNC;
                    pid_s       = tx_pid;
                    busy_s      = 1'b1;
                    load_byte_s = 1'b1;
                    load_val_s  = SYNC_BYTE;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_SYNC, ST_PID, ST_DATA: begin
                if (!wrap_s) begin
                    state_s = state_r;
                end else if (STUFF_EN && ones_r == 3'd6) begin
                    // stuffed 0: shift register and byte fetch both wait one bit period
                    emit_bit_s = 1'b1;
                    bit_val_s  = 1'b0;
                end else if (bit_idx_r != 4'd8) begin
                    emit_bit_s = 1'b1;
                    bit_val_s  = shift_r[0];
                    advance_s  = 1'b1;
                end else if (state_r == ST_SYNC) begin
                    state_s     = ST_PID;
                    load_byte_s = 1'b1;
                    load_val_s  = {~pid_r, pid_r};
                end else if (!fifo_empty) begin
                    state_s     = ST_DATA;
                    pop_s       = 1'b1;
                    load_byte_s = 1'b1;
                    load_val_s  = fifo_r_data;
                end else begin
                    state_s    = ST_EOP_SE0;
                    emit_se0_s = 1'b1;
                    se0_cnt_s  = SW'(1'b1);
                end
            end
            ST_EOP_SE0: begin
                if (!wrap_s) begin
                    state_s = state_r;
                end else if (se0_cnt_r == SE0_LAST) begin
                    state_s  = ST_EOP_J;
                    emit_j_s = 1'b1;
                end else begin
                    se0_cnt_s = se0_cnt_r + SW'(1'b1);
                end
            end
            ST_EOP_J: begin
                if (wrap_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase

        if (load_byte_s) begin
            shift_s    = {1'b0, load_val_s[7:1]};
            bit_idx_s  = 4'd1;
            emit_bit_s = 1'b1;
            bit_val_s  = load_val_s[0];
        end else if (advance_s) begin
            shift_s   = {1'b0, shift_r[7:1]};
            bit_idx_s = bit_idx_r + 4'd1;
        end else begin
            shift_s   = shift_r;
            bit_idx_s = bit_idx_r;
        end

        if (emit_bit_s) begin
            level_s   = nrzi_level(level_r, bit_val_s);
            d_plus_s  = level_s;
            d_minus_s = ~level_s;
            ones_s    = bit_val_s ? ones_r + 3'd1 : 3'd0;
        end else if (emit_se0_s) begin
            level_s   = level_r;
            d_plus_s  = 1'b0;
            d_minus_s = 1'b0;
            ones_s    = 3'd0;
        end else if (emit_j_s) begin
            level_s   = 1'b1;
            d_plus_s  = 1'b1;
            d_minus_s = 1'b0;
            ones_s    = 3'd0;
        end else begin
            level_s   = level_r;
            d_plus_s  = d_plus_r;
            d_minus_s = d_minus_r;
            ones_s    = ones_r;
        end
    end

    // State and output registers with synchronous reset to an idle J line
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            timer_r   <= {TW{1'b0}};
            bit_idx_r <= 4'd0;
            shift_r   <= 8'h00;
            pid_r     <= 4'h0;
            ones_r    <= 3'd0;
            se0_cnt_r <= {SW{1'b0}};
            level_r   <= 1'b1;
            d_plus_r  <= 1'b1;
            d_minus_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            pid_r     <= pid_s;
            ones_r    <= ones_s;
            se0_cnt_r <= se0_cnt_s;
            level_r   <= level_s;
            d_plus_r  <= d_plus_s;
            d_minus_r <= d_minus_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    // The pop must coincide with the latch of the head byte, so it is decoded, not registered
    assign fifo_r_enable = pop_s & ~rst;
    assign d_plus        = d_plus_r;
    assign d_minus       = d_minus_r;
    assign tx_busy       = busy_r;
    assign tx_done       = done_r;

endmodule

// File: tb/tb_usb_transmitter.sv
// Directed bench for usb_transmitter: a stuffing and a non-stuffing instance share stimulus;
// captured line traces are NRZI-decoded and compared against hand-computed packets.
module tb_usb_transmitter;
    localparam int CPB  = 8;
    localparam int NCAP = 400;

    logic       tb_clk = 1'b0;
    logic       rst, tx_start;
    logic [3:0] tx_pid;
    logic [7:0] fifo_r_data_a, fifo_r_data_b;
    logic       fifo_empty_a, fifo_empty_b;
    logic       fifo_r_enable_a, fifo_r_enable_b;
    logic       d_plus_a, d_minus_a, tx_busy_a, tx_done_a;
    logic       d_plus_b, d_minus_b, tx_busy_b, tx_done_b;

    int errors = 0;
    int checks = 0;

    always #5 tb_clk = ~tb_clk;

    usb_transmitter #(.CLKS_PER_BIT(CPB), .EOP_SE0_BITS(2), .STUFF_EN(1'b1)) u_dut (
        .clk(tb_clk), .rst(rst), .tx_start(tx_start), .tx_pid(tx_pid),
        .fifo_r_data(fifo_r_data_a), .fifo_empty(fifo_empty_a), .fifo_r_enable(fifo_r_enable_a),
        .d_plus(d_plus_a), .d_minus(d_minus_a), .tx_busy(tx_busy_a), .tx_done(tx_done_a)
    );

    usb_transmitter #(.CLKS_PER_BIT(CPB), .EOP_SE0_BITS(2), .STUFF_EN(1'b0)) u_dut_ns (
        .clk(tb_clk), .rst(rst), .tx_start(tx_start), .tx_pid(tx_pid),
        .fifo_r_data(fifo_r_data_b), .fifo_empty(fifo_empty_b), .fifo_r_enable(fifo_r_enable_b),
        .d_plus(d_plus_b), .d_minus(d_minus_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b)
    );

    // Show-ahead FIFO models, one per instance
    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];
    logic [7:0] rd_a = 8'd0, rd_b = 8'd0, wr_a = 8'd0, wr_b = 8'd0;
    assign fifo_empty_a  = (rd_a == wr_a);
    assign fifo_empty_b  = (rd_b == wr_b);
    assign fifo_r_data_a = mem_a[rd_a];
    assign fifo_r_data_b = mem_b[rd_b];

    // Advance the FIFO heads on each pop strobe
    always @(posedge tb_clk) begin
        if (fifo_r_enable_a) rd_a <= rd_a + 8'd1;
        if (fifo_r_enable_b) rd_b <= rd_b + 8'd1;
    end

    logic dp_a [0:NCAP-1], dm_a [0:NCAP-1], pop_a [0:NCAP-1], done_a [0:NCAP-1], busy_a [0:NCAP-1];
    logic dp_b [0:NCAP-1], dm_b [0:NCAP-1], pop_b [0:NCAP-1], done_b [0:NCAP-1];

    int         dec_npre, dec_stuffs, dec_stuff_pos;
    logic       dec_ok, dec_eop_ok;
    logic [7:0] dec_bytes [$];
    logic [39:0] dec_word;

    task automatic load_fifo(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        mem_a[rd_a] = b0; mem_a[rd_a + 8'd1] = b1; mem_a[rd_a + 8'd2] = b2;
        mem_b[rd_b] = b0; mem_b[rd_b + 8'd1] = b1; mem_b[rd_b + 8'd2] = b2;
        wr_a = rd_a + 8'(n);
        wr_b = rd_b + 8'(n);
    endtask

    // Capture cycle 0 is the first cycle after the edge that accepts tx_start
    task automatic run_packet(input logic [3:0] pid, input int start_again_at, input int rst_at);
        @(negedge tb_clk);
        tx_pid   = pid;
        tx_start = 1'b1;
        for (int c = 0; c < NCAP; c++) begin
            @(negedge tb_clk);
            dp_a[c] = d_plus_a; dm_a[c] = d_minus_a; pop_a[c] = fifo_r_enable_a;
            done_a[c] = tx_done_a; busy_a[c] = tx_busy_a;
            dp_b[c] = d_plus_b; dm_b[c] = d_minus_b; pop_b[c] = fifo_r_enable_b; done_b[c] = tx_done_b;
            tx_start = (c == start_again_at);
            rst = (rst_at >= 0) && (c >= rst_at) && (c < rst_at + 2);
        end
        tx_start = 1'b0;
        rst      = 1'b0;
    endtask

    function automatic int count_hi(input int sel);
        int n = 0;
        for (int c = 0; c < NCAP; c++) begin
            case (sel)
                0: n += (pop_a[c] === 1'b1) ? 1 : 0;
                1: n += (done_a[c] === 1'b1) ? 1 : 0;
                2: n += (pop_b[c] === 1'b1) ? 1 : 0;
                default: n += (done_b[c] === 1'b1) ? 1 : 0;
            endcase
        end
        return n;
    endfunction

    // Receiver-side view: sample each bit period, NRZI-decode, drop stuffed bits, stop at SE0
    task automatic decode(input bit use_b, input bit destuff);
        logic lp, lm, prev, b, cp, cm;
        int ones, nbits;
        logic [7:0] cur;
        dec_npre = -1; dec_stuffs = 0; dec_stuff_pos = -1; dec_ok = 1'b1; dec_eop_ok = 1'b0;
        dec_bytes.delete();
        prev = 1'b1; ones = 0; nbits = 0; cur = 8'h00;
        for (int k = 0; k < NCAP / CPB; k++) begin
            lp = use_b ? dp_b[k*CPB] : dp_a[k*CPB];
            lm = use_b ? dm_b[k*CPB] : dm_a[k*CPB];
            for (int c = 1; c < CPB; c++) begin
                cp = use_b ? dp_b[k*CPB+c] : dp_a[k*CPB+c];
                cm = use_b ? dm_b[k*CPB+c] : dm_a[k*CPB+c];
                if (cp !== lp || cm !== lm) dec_ok = 1'b0;
            end
            if (lp === 1'b0 && lm === 1'b0) begin
                dec_npre = k;
                break;
            end
            if (lm !== ~lp) dec_ok = 1'b0;
            b = (lp === prev);
            prev = lp;
            if (destuff && ones == 6) begin
                if (b !== 1'b0) dec_ok = 1'b0;
                dec_stuffs++;
                dec_stuff_pos = k;
                ones = 0;
            end else begin
                cur = {b, cur[7:1]};
                nbits++;
                ones = b ? ones + 1 : 0;
                if (nbits % 8 == 0) dec_bytes.push_back(cur);
            end
        end
        if (dec_npre >= 0 && dec_npre + 2 < NCAP / CPB) begin
            dec_eop_ok = use_b ?
                (dp_b[(dec_npre+1)*CPB+4] === 1'b0 && dm_b[(dec_npre+1)*CPB+4] === 1'b0 &&
                 dp_b[(dec_npre+2)*CPB+4] === 1'b1 && dm_b[(dec_npre+2)*CPB+4] === 1'b0) :
                (dp_a[(dec_npre+1)*CPB+4] === 1'b0 && dm_a[(dec_npre+1)*CPB+4] === 1'b0 &&
                 dp_a[(dec_npre+2)*CPB+4] === 1'b1 && dm_a[(dec_npre+2)*CPB+4] === 1'b0);
        end
        dec_word = 40'h0;
        for (int i = 0; i < dec_bytes.size() && i < 5; i++) dec_word[8*i +: 8] = dec_bytes[i];
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_start = 1'b0; tx_pid = 4'h0;
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        checks++; if (d_plus_a !== 1'b1) begin errors++; $display("FAIL reset_dplus: got %b expected 1", d_plus_a); end
        checks++; if (d_minus_a !== 1'b0) begin errors++; $display("FAIL reset_dminus: got %b expected 0", d_minus_a); end
        checks++; if (tx_busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy_a); end
        checks++; if (tx_done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", tx_done_a); end
        checks++; if (fifo_r_enable_a !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b expected 0", fifo_r_enable_a); end
        rst = 1'b0;
    endtask

    task automatic test_pid_only();
        logic [18:0] got_dp, got_dm;
        load_fifo(0, 8'h00, 8'h00, 8'h00);
        run_packet(4'b0001, -1, -1);
        for (int k = 0; k < 19; k++) begin
            got_dp[k] = dp_a[k*CPB+4];
            got_dm[k] = dm_a[k*CPB+4];
        end
        checks++; if (dp_a[0] !== 1'b0) begin errors++; $display("FAIL pid_first_sync_bit: got %b expected 0", dp_a[0]); end
        checks++; if (got_dp !== 19'b1000000_1010_0010_1010) begin errors++; $display("FAIL pid_only_dplus: got %b expected %b", got_dp, 19'b1000000_1010_0010_1010); end
        checks++; if (got_dm !== 19'b0001111_0101_1101_0101) begin errors++; $display("FAIL pid_only_dminus: got %b expected %b", got_dm, 19'b0001111_0101_1101_0101); end
        checks++; if (done_a[152] !== 1'b1) begin errors++; $display("FAIL pid_done_at_152: got %b expected 1", done_a[152]); end
        checks++; if (count_hi(1) != 1) begin errors++; $display("FAIL pid_done_count: got %0d expected 1", count_hi(1)); end
        checks++; if (count_hi(0) != 0) begin errors++; $display("FAIL pid_no_pop: got %0d expected 0", count_hi(0)); end
        checks++; if (busy_a[151] !== 1'b1 || busy_a[152] !== 1'b0) begin errors++; $display("FAIL pid_busy_edge: got %b%b expected 10", busy_a[151], busy_a[152]); end
    endtask

    task automatic test_one_byte();
        load_fifo(1, 8'h55, 8'h00, 8'h00);
        run_packet(4'b0011, -1, -1);
        decode(1'b0, 1'b1);
        checks++; if (count_hi(0) != 1) begin errors++; $display("FAIL one_pop_count: got %0d expected 1", count_hi(0)); end
        checks++; if (pop_a[127] !== 1'b1) begin errors++; $display("FAIL one_pop_at_127: got %b expected 1", pop_a[127]); end
        checks++; if (dec_npre != 24) begin errors++; $display("FAIL one_bits_before_eop: got %0d expected 24", dec_npre); end
        checks++; if (dec_word !== 40'h00_0055_C380 || dec_bytes.size() != 3) begin errors++; $display("FAIL one_bytes: got %h (%0d) expected 000055c380 (3)", dec_word, dec_bytes.size()); end
        checks++; if (dec_ok !== 1'b1 || dec_eop_ok !== 1'b1) begin errors++; $display("FAIL one_line_format: got %b%b expected 11", dec_ok, dec_eop_ok); end
        checks++; if (done_a[216] !== 1'b1) begin errors++; $display("FAIL one_done_at_216: got %b expected 1", done_a[216]); end
    endtask

    task automatic test_three_bytes();
        load_fifo(3, 8'h00, 8'h40, 8'h61);
        run_packet(4'b0001, -1, -1);
        decode(1'b0, 1'b1);
        checks++; if (count_hi(0) != 3) begin errors++; $display("FAIL three_pop_count: got %0d expected 3", count_hi(0)); end
        checks++; if (pop_a[127] !== 1'b1 || pop_a[191] !== 1'b1 || pop_a[255] !== 1'b1) begin errors++; $display("FAIL three_pop_spacing: got %b%b%b expected 111", pop_a[127], pop_a[191], pop_a[255]); end
        checks++; if (dec_word !== 40'h61_4000_E180 || dec_bytes.size() != 5) begin errors++; $display("FAIL three_bytes: got %h (%0d) expected 614000e180 (5)", dec_word, dec_bytes.size()); end
        checks++; if (dec_npre != 40 || dec_ok !== 1'b1) begin errors++; $display("FAIL three_bits_before_eop: got %0d/%b expected 40/1", dec_npre, dec_ok); end
        checks++; if (count_hi(1) != 1 || done_a[344] !== 1'b1) begin errors++; $display("FAIL three_done: got %0d/%b expected 1/1", count_hi(1), done_a[344]); end
    endtask

    task automatic test_stuffing();
        load_fifo(1, 8'hFF, 8'h00, 8'h00);
        run_packet(4'b0001, -1, -1);
        decode(1'b0, 1'b1);
        checks++; if (dec_npre != 25 || dec_stuffs != 1 || dec_stuff_pos != 19) begin errors++; $display("FAIL stuff_ff: got npre=%0d stuffs=%0d pos=%0d expected 25 1 19", dec_npre, dec_stuffs, dec_stuff_pos); end
        checks++; if (dec_word !== 40'h00_00FF_E180 || dec_ok !== 1'b1 || dec_eop_ok !== 1'b1) begin errors++; $display("FAIL stuff_ff_bytes: got %h ok=%b%b expected 0000ffe180 ok=11", dec_word, dec_ok, dec_eop_ok); end
        checks++; if (done_a[224] !== 1'b1) begin errors++; $display("FAIL stuff_ff_done_224: got %b expected 1", done_a[224]); end
        decode(1'b1, 1'b0);
        checks++; if (dec_npre != 24 || dec_word !== 40'h00_00FF_E180) begin errors++; $display("FAIL nostuff_ff: got npre=%0d bytes=%h expected 24 0000ffe180", dec_npre, dec_word); end
        checks++; if (done_b[216] !== 1'b1 || count_hi(2) != 1) begin errors++; $display("FAIL nostuff_ff_done: got %b/%0d expected 1/1", done_b[216], count_hi(2)); end
        // Six trailing ones: the stuffed bit lands after the last data bit, before SE0
        load_fifo(1, 8'hFC, 8'h00, 8'h00);
        run_packet(4'b0001, -1, -1);
        decode(1'b0, 1'b1);
        checks++; if (dec_npre != 25 || dec_stuff_pos != 24 || dec_word !== 40'h00_00FC_E180) begin errors++; $display("FAIL stuff_tail: got npre=%0d pos=%0d bytes=%h expected 25 24 0000fce180", dec_npre, dec_stuff_pos, dec_word); end
        decode(1'b1, 1'b0);
        checks++; if (dec_npre != 24) begin errors++; $display("FAIL nostuff_tail: got %0d expected 24", dec_npre); end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        load_fifo(2, 8'hA5, 8'h3C, 8'h00);
        run_packet(4'b0010, 150, -1);
        decode(1'b0, 1'b1);
        for (int c = 281; c < NCAP; c++) if (busy_a[c] !== 1'b0 || dp_a[c] !== 1'b1 || dm_a[c] !== 1'b0) bad++;
        checks++; if (count_hi(1) != 1 || done_a[280] !== 1'b1) begin errors++; $display("FAIL busy_start_done: got %0d/%b expected 1/1", count_hi(1), done_a[280]); end
        checks++; if (count_hi(0) != 2) begin errors++; $display("FAIL busy_start_pops: got %0d expected 2", count_hi(0)); end
        checks++; if (dec_npre != 32 || dec_word !== 40'h00_3CA5_D280) begin errors++; $display("FAIL busy_start_packet: got %0d %h expected 32 003ca5d280", dec_npre, dec_word); end
        checks++; if (bad != 0) begin errors++; $display("FAIL busy_start_idle_after: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_reset_mid_data();
        int bad = 0;
        load_fifo(2, 8'h00, 8'h00, 8'h00);
        run_packet(4'b0001, -1, 150);
        for (int c = 151; c < NCAP; c++)
            if (dp_a[c] !== 1'b1 || dm_a[c] !== 1'b0 || busy_a[c] !== 1'b0 || pop_a[c] !== 1'b0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_line_j: got %0d bad cycles expected 0", bad); end
        checks++; if (count_hi(0) != 1) begin errors++; $display("FAIL rst_mid_pops: got %0d expected 1", count_hi(0)); end
        checks++; if (count_hi(1) != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d expected 0", count_hi(1)); end
    endtask

    task automatic test_reset_with_start();
        int bad = 0;
        logic [7:0] rd_before;
        load_fifo(1, 8'h12, 8'h00, 8'h00);
        rd_before = rd_a;
        @(negedge tb_clk);
        rst = 1'b1; tx_start = 1'b1; tx_pid = 4'b0001;
        @(negedge tb_clk);
        rst = 1'b0; tx_start = 1'b0;
        for (int c = 0; c < 120; c++) begin
            @(negedge tb_clk);
            if (tx_busy_a !== 1'b0 || d_plus_a !== 1'b1 || d_minus_a !== 1'b0 || fifo_r_enable_a !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_start_line_j: got %0d bad cycles expected 0", bad); end
        checks++; if (rd_a !== rd_before) begin errors++; $display("FAIL rst_start_no_pop: got %0d expected %0d", rd_a, rd_before); end
    endtask

    initial begin
        test_reset();
        test_pid_only();
        test_one_byte();
        test_three_bytes();
        test_stuffing();
        test_back_to_back();
        test_reset_mid_data();
        test_reset_with_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
